// File: rtl/spi_slave.sv
// SPI mode-0 slave: oversamples sclk/ss/mosi in the clk domain, deserialises
// MOSI into DATA_WIDTH-bit words (MSB first) and serialises a preloaded
// transmit byte onto MISO. Local side sees a load/ready and data/valid pair.
module spi_slave #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sclk,
    input  logic                  ss,
    input  logic                  mosi,
    output logic                  miso,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_load,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  tx_underrun,
    output logic                  busy
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic [0:0] {
        IDLE,
        SHIFT
    } state_t;

    // Synchroniser chains and edge-detect history
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] ss_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sclk_prev_q;
    logic                   ss_prev_q;

    logic sclk_s, ss_s, mosi_s;
    logic sclk_rise, sclk_fall, ss_rise, ss_fall;

    // Protocol state
    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  word_done_q, word_done_d;
    logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_WIDTH-1:0] tx_buf_q, tx_buf_d;
    logic                  tx_ready_q, tx_ready_d;
    logic                  rx_pend_q, rx_pend_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  underrun_q, underrun_d;
    logic                  miso_q, miso_d;
    logic                  consume;

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign ss_s   = ss_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign ss_rise   = ss_s & ~ss_prev_q;
    assign ss_fall   = ~ss_s & ss_prev_q;

    // Bring the SPI pins into the clk domain; reset presets them to bus idle
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_sync_q <= '0;
            ss_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            ss_prev_q   <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            sclk_prev_q <= sclk_s;
            ss_prev_q   <= ss_s;
        end
    end

    // Next-state logic for the word engine, transmit buffer and outputs
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        word_done_d = word_done_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        tx_buf_d    = tx_buf_q;
        tx_ready_d  = tx_ready_q;
        rx_pend_d   = 1'b0;
        underrun_d  = 1'b0;
        consume     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (ss_fall) begin
                    consume     = 1'b1;
                    cnt_d       = '0;
                    word_done_d = 1'b0;
                    state_d     = SHIFT;
                end
            end
            SHIFT: begin
                if (ss_rise) begin
                    state_d     = IDLE;
                    cnt_d       = '0;
                    word_done_d = 1'b0;
                    tx_shift_d  = '0;
                end else begin
                    if (sclk_rise) begin
                        rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
                        if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                            cnt_d       = '0;
                            word_done_d = 1'b1;
                            rx_pend_d   = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    if (sclk_fall) begin
                        if (word_done_q) begin
                            consume     = 1'b1;
                            word_done_d = 1'b0;
                        end else begin
                            tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Word start: take the buffered byte, or send zeros and flag underrun
        if (consume) begin
            if (!tx_ready_q) begin
                tx_shift_d = tx_buf_q;
                tx_ready_d = 1'b1;
            end else begin
                tx_shift_d = '0;
                underrun_d = 1'b1;
            end
        end

        // Evaluated after consume so a load into an empty buffer on the same
        // cycle as a word start is kept for the following word
        if (tx_load && tx_ready_q) begin
            tx_buf_d   = tx_data;
            tx_ready_d = 1'b0;
        end

        rx_data_d  = rx_pend_q ? rx_shift_q : rx_data_q;
        rx_valid_d = rx_pend_q;
        miso_d     = (state_d == SHIFT) ? tx_shift_d[DATA_WIDTH-1] : 1'b0;
    end

    // State and registered-output update
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            word_done_q <= 1'b0;
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
            tx_buf_q    <= '0;
            tx_ready_q  <= 1'b1;
            rx_pend_q   <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
            miso_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            word_done_q <= word_done_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            tx_buf_q    <= tx_buf_d;
            tx_ready_q  <= tx_ready_d;
            rx_pend_q   <= rx_pend_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            underrun_q  <= underrun_d;
            miso_q      <= miso_d;
        end
    end

    assign miso        = miso_q;
    assign tx_ready    = tx_ready_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_underrun = underrun_q;
    assign busy        = (state_q == SHIFT);

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: a mode-0 master model at clk/8 plus a
// word-level model of the transmit buffer (full/empty, underrun on empty).
module tb_spi_slave;

    typedef logic [7:0] byte4_t [4];
    typedef bit         bit4_t  [4];

    logic       clk = 1'b0;
    logic       reset, sclk, ss, mosi, miso;
    logic [7:0] tx_data, rx_data;
    logic       tx_load, tx_ready, rx_valid, tx_underrun, busy;

    int errors = 0;
    int checks = 0;

    // Observed event history
    int         rx_cnt = 0;
    int         ur_cnt = 0;
    logic [7:0] rxq[$];

    // Reference model of the transmit buffer
    bit         m_full;
    logic [7:0] m_buf;
    int         m_ur;

    always #5 clk = ~clk;

    spi_slave #(
        .DATA_WIDTH (8),
        .SYNC_STAGES(2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sclk       (sclk),
        .ss         (ss),
        .mosi       (mosi),
        .miso       (miso),
        .tx_data    (tx_data),
        .tx_load    (tx_load),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_underrun(tx_underrun),
        .busy       (busy)
    );

    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            if (rx_valid === 1'b1) begin
                rx_cnt++;
                rxq.push_back(rx_data);
            end
            if (tx_underrun === 1'b1) ur_cnt++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // A word starts: the master sees the buffered byte, or zeros if empty
    function automatic logic [7:0] consume();
        if (m_full) begin
            m_full = 1'b0;
            return m_buf;
        end
        m_ur++;
        return 8'h00;
    endfunction

    task automatic do_load(input logic [7:0] d);
        tx_data = d;
        tx_load = 1'b1;
        cyc(1);
        tx_load = 1'b0;
        if (!m_full) begin
            m_full = 1'b1;
            m_buf  = d;
        end
    endtask

    // Mode 0: data set while sclk low, sampled by both sides on sclk rise
    task automatic shift_bits(input logic [7:0] b, input int nb, output logic [7:0] got);
        got = '0;
        for (int i = 0; i < nb; i++) begin
            mosi = b[7-i];
            cyc(4);
            got  = {got[6:0], miso};
            sclk = 1'b1;
            cyc(4);
            sclk = 1'b0;
        end
    endtask

    task automatic run_session(input int nw, input byte4_t mo, input bit4_t ld_en,
                               input byte4_t ld_d, output byte4_t got, output byte4_t exp,
                               output logic st_rdy, output logic st_busy, output int st_ur);
        int         ur0;
        logic [7:0] nxt;
        foreach (got[k]) begin
            got[k] = '0;
            exp[k] = '0;
        end
        ur0     = ur_cnt;
        ss      = 1'b0;
        exp[0]  = consume();
        cyc(6);
        st_rdy  = tx_ready;
        st_busy = busy;
        st_ur   = ur_cnt - ur0;
        for (int w = 0; w < nw; w++) begin
            if (ld_en[w]) do_load(ld_d[w]);
            shift_bits(mo[w], 8, got[w]);
            nxt = consume();
            cyc(6);
            if (w + 1 < 4) exp[w+1] = nxt;
        end
        ss = 1'b1;
        cyc(8);
    endtask

    task automatic test_reset();
        reset = 1'b1; sclk = 1'b0; ss = 1'b1; mosi = 1'b0;
        tx_load = 1'b0; tx_data = '0;
        m_full = 1'b0; m_buf = '0; m_ur = 0;
        cyc(3);
        checks++; if (miso !== 1'b0) begin errors++; $display("FAIL reset_miso got=%b exp=0", miso); end
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_tx_ready got=%b exp=1", tx_ready); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
        checks++; if (tx_underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun got=%b exp=0", tx_underrun); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        reset = 1'b0;
        cyc(4);
    endtask

    task automatic test_basic();
        byte4_t mo, ld_d, got, exp;
        bit4_t  ld_en;
        logic   st_rdy, st_busy;
        int     st_ur, rc0;
        rxq.delete();
        mo = '{8'h3C, 8'h00, 8'h00, 8'h00};
        ld_en = '{0, 0, 0, 0};
        ld_d = '{8'h00, 8'h00, 8'h00, 8'h00};
        do_load(8'hA5);
        checks++; if (tx_ready !== m_full ^ 1'b1) begin errors++; $display("FAIL basic_ready_after_load got=%b exp=0", tx_ready); end
        rc0 = rx_cnt;
        run_session(1, mo, ld_en, ld_d, got, exp, st_rdy, st_busy, st_ur);
        checks++; if (st_rdy !== 1'b1) begin errors++; $display("FAIL basic_ready_at_ss_fall got=%b exp=1", st_rdy); end
        checks++; if (st_busy !== 1'b1) begin errors++; $display("FAIL basic_busy_in_word got=%b exp=1", st_busy); end
        checks++; if (got[0] !== exp[0]) begin errors++; $display("FAIL basic_miso got=%h exp=%h", got[0], exp[0]); end
        checks++; if (rx_cnt - rc0 !== 1) begin errors++; $display("FAIL basic_rx_valid_count got=%0d exp=1", rx_cnt - rc0); end
        checks++; if (rx_data !== 8'h3C) begin errors++; $display("FAIL basic_rx_data got=%h exp=3c", rx_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after got=%b exp=0", busy); end
        checks++; if (ur_cnt !== m_ur) begin errors++; $display("FAIL basic_underruns got=%0d exp=%0d", ur_cnt, m_ur); end
    endtask

    task automatic test_underrun();
        byte4_t mo, ld_d, got, exp;
        bit4_t  ld_en;
        logic   st_rdy, st_busy;
        int     st_ur, rc0;
        mo = '{8'hFF, 8'h00, 8'h00, 8'h00};
        ld_en = '{0, 0, 0, 0};
        ld_d = '{8'h00, 8'h00, 8'h00, 8'h00};
        rc0 = rx_cnt;
        run_session(1, mo, ld_en, ld_d, got, exp, st_rdy, st_busy, st_ur);
        checks++; if (st_ur !== 1) begin errors++; $display("FAIL underrun_at_start got=%0d exp=1", st_ur); end
        checks++; if (got[0] !== exp[0]) begin errors++; $display("FAIL underrun_miso got=%h exp=%h", got[0], exp[0]); end
        checks++; if (rx_data !== 8'hFF) begin errors++; $display("FAIL underrun_rx_data got=%h exp=ff", rx_data); end
        checks++; if (rx_cnt - rc0 !== 1) begin errors++; $display("FAIL underrun_rx_count got=%0d exp=1", rx_cnt - rc0); end
        checks++; if (ur_cnt !== m_ur) begin errors++; $display("FAIL underrun_total got=%0d exp=%0d", ur_cnt, m_ur); end
    endtask

    task automatic test_back_to_back();
        byte4_t mo, ld_d, got, exp;
        bit4_t  ld_en;
        logic   st_rdy, st_busy;
        int     st_ur, rc0;
        rxq.delete();
        mo = '{8'h01, 8'h80, 8'h55, 8'h00};
        ld_en = '{1, 1, 0, 0};
        ld_d = '{8'h22, 8'h33, 8'h00, 8'h00};
        do_load(8'h11);
        rc0 = rx_cnt;
        run_session(3, mo, ld_en, ld_d, got, exp, st_rdy, st_busy, st_ur);
        for (int w = 0; w < 3; w++) begin
            checks++; if (got[w] !== exp[w]) begin errors++; $display("FAIL b2b_miso[%0d] got=%h exp=%h", w, got[w], exp[w]); end
        end
        checks++; if (rx_cnt - rc0 !== 3) begin errors++; $display("FAIL b2b_rx_count got=%0d exp=3", rx_cnt - rc0); end
        for (int w = 0; w < 3; w++) begin
            checks++;
            if (rxq.size() <= w || rxq[w] !== mo[w]) begin
                errors++;
                $display("FAIL b2b_rx_data[%0d] got=%h exp=%h", w, (rxq.size() > w) ? rxq[w] : 8'hxx, mo[w]);
            end
        end
        checks++; if (ur_cnt !== m_ur) begin errors++; $display("FAIL b2b_underruns got=%0d exp=%0d", ur_cnt, m_ur); end
    endtask

    task automatic test_abort();
        byte4_t     mo, ld_d, got, exp;
        bit4_t      ld_en;
        logic       st_rdy, st_busy;
        logic [7:0] rd0, g;
        int         st_ur, rc0;
        rd0 = rx_data;
        rc0 = rx_cnt;
        ss = 1'b0;
        void'(consume());
        cyc(6);
        shift_bits(8'hE7, 5, g);
        ss = 1'b1;
        cyc(10);
        checks++; if (rx_cnt !== rc0) begin errors++; $display("FAIL abort_no_valid got=%0d exp=%0d", rx_cnt, rc0); end
        checks++; if (rx_data !== rd0) begin errors++; $display("FAIL abort_rx_held got=%h exp=%h", rx_data, rd0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
        mo = '{8'h96, 8'h00, 8'h00, 8'h00};
        ld_en = '{0, 0, 0, 0};
        ld_d = '{8'h00, 8'h00, 8'h00, 8'h00};
        run_session(1, mo, ld_en, ld_d, got, exp, st_rdy, st_busy, st_ur);
        checks++; if (rx_data !== 8'h96) begin errors++; $display("FAIL abort_next_word got=%h exp=96", rx_data); end
        checks++; if (rx_cnt - rc0 !== 1) begin errors++; $display("FAIL abort_next_count got=%0d exp=1", rx_cnt - rc0); end
        checks++; if (got[0] !== exp[0]) begin errors++; $display("FAIL abort_next_miso got=%h exp=%h", got[0], exp[0]); end
    endtask

    task automatic test_double_load();
        byte4_t mo, ld_d, got, exp;
        bit4_t  ld_en;
        logic   st_rdy, st_busy;
        int     st_ur;
        do_load(8'h12);
        do_load(8'h34);
        checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL dbl_ready got=%b exp=0", tx_ready); end
        mo = '{8'($urandom), 8'h00, 8'h00, 8'h00};
        ld_en = '{0, 0, 0, 0};
        ld_d = '{8'h00, 8'h00, 8'h00, 8'h00};
        run_session(1, mo, ld_en, ld_d, got, exp, st_rdy, st_busy, st_ur);
        checks++; if (got[0] !== exp[0]) begin errors++; $display("FAIL dbl_miso got=%h exp=%h", got[0], exp[0]); end
        checks++; if (rx_data !== mo[0]) begin errors++; $display("FAIL dbl_rx_data got=%h exp=%h", rx_data, mo[0]); end
    endtask

    task automatic test_reset_midword();
        byte4_t     mo, ld_d, got, exp;
        bit4_t      ld_en;
        logic       st_rdy, st_busy;
        logic [7:0] g;
        int         st_ur, rc0;
        do_load(8'h5A);
        ss = 1'b0;
        void'(consume());
        cyc(6);
        shift_bits(8'hB4, 4, g);
        reset = 1'b1;
        cyc(1);
        checks++; if (miso !== 1'b0) begin errors++; $display("FAIL rstmid_miso got=%b exp=0", miso); end
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL rstmid_tx_ready got=%b exp=1", tx_ready); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rstmid_rx_data got=%h exp=00", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rstmid_rx_valid got=%b exp=0", rx_valid); end
        checks++; if (tx_underrun !== 1'b0) begin errors++; $display("FAIL rstmid_underrun got=%b exp=0", tx_underrun); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        reset = 1'b0;
        ss = 1'b1;
        mosi = 1'b0;
        m_full = 1'b0;
        cyc(8);
        rc0 = rx_cnt;
        mo = '{8'hC3, 8'h00, 8'h00, 8'h00};
        ld_en = '{0, 0, 0, 0};
        ld_d = '{8'h00, 8'h00, 8'h00, 8'h00};
        run_session(1, mo, ld_en, ld_d, got, exp, st_rdy, st_busy, st_ur);
        checks++; if (rx_data !== 8'hC3) begin errors++; $display("FAIL rstmid_next_word got=%h exp=c3", rx_data); end
        checks++; if (rx_cnt - rc0 !== 1) begin errors++; $display("FAIL rstmid_next_count got=%0d exp=1", rx_cnt - rc0); end
        checks++; if (got[0] !== exp[0]) begin errors++; $display("FAIL rstmid_next_miso got=%h exp=%h", got[0], exp[0]); end
        checks++; if (ur_cnt !== m_ur) begin errors++; $display("FAIL rstmid_underruns got=%0d exp=%0d", ur_cnt, m_ur); end
    endtask

    task automatic test_random();
        byte4_t mo, ld_d, got, exp;
        bit4_t  ld_en;
        logic   st_rdy, st_busy;
        int     st_ur, rc0, nw;
        for (int s = 0; s < 8; s++) begin
            rxq.delete();
            if ($urandom_range(0, 1) == 1) do_load(8'($urandom));
            nw = $urandom_range(1, 3);
            for (int k = 0; k < 4; k++) begin
                mo[k]    = 8'($urandom);
                ld_en[k] = bit'($urandom_range(0, 1));
                ld_d[k]  = 8'($urandom);
            end
            rc0 = rx_cnt;
            run_session(nw, mo, ld_en, ld_d, got, exp, st_rdy, st_busy, st_ur);
            for (int w = 0; w < nw; w++) begin
                checks++; if (got[w] !== exp[w]) begin errors++; $display("FAIL rand%0d_miso[%0d] got=%h exp=%h", s, w, got[w], exp[w]); end
                checks++;
                if (rxq.size() <= w || rxq[w] !== mo[w]) begin
                    errors++;
                    $display("FAIL rand%0d_rx[%0d] got=%h exp=%h", s, w, (rxq.size() > w) ? rxq[w] : 8'hxx, mo[w]);
                end
            end
            checks++; if (rx_cnt - rc0 !== nw) begin errors++; $display("FAIL rand%0d_rx_count got=%0d exp=%0d", s, rx_cnt - rc0, nw); end
            checks++; if (ur_cnt !== m_ur) begin errors++; $display("FAIL rand%0d_underruns got=%0d exp=%0d", s, ur_cnt, m_ur); end
            checks++; if (tx_ready !== !m_full) begin errors++; $display("FAIL rand%0d_tx_ready got=%b exp=%b", s, tx_ready, !m_full); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_underrun();
        test_back_to_back();
        test_abort();
        test_double_load();
        test_reset_midword();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI mode-0 slave; the peripheral-side counterpart of the team's SPI master.
- Oversamples `sclk`/`ss`/`mosi` in the local `clk` domain and deserialises MOSI into parallel bytes.
- Serialises a preloaded transmit byte onto MISO.
- Presents a simple parallel load/valid interface to local logic.

Parameters:
- DATA_WIDTH, 8: bits per SPI word; MSB first.
- SYNC_STAGES, 2: synchroniser flops on `sclk`, `ss` and `mosi`; minimum 2.

Ports:
- clk  input  1  system clock; must be at least 4x the `sclk` frequency.
- reset  input  1  synchronous, active-high reset.
- sclk  input  1  SPI clock from the master; idles low.
- ss  input  1  slave select, active low.
- mosi  input  1  serial data from the master.
- miso  output  1  serial data to the master.
- tx_data  input  DATA_WIDTH  byte to transmit.
- tx_load  input  1  write strobe for `tx_data`; accepted only when `tx_ready`=1.
- tx_ready  output  1  transmit buffer empty.
- rx_data  output  DATA_WIDTH  last complete received byte; held until the next byte completes.
- rx_valid  output  1  one-cycle pulse when `rx_data` updates.
- tx_underrun  output  1  one-cycle pulse when a word starts with the transmit buffer empty.
- busy  output  1  high while `ss` (synchronised) is low.

Behaviour:
- Reset (synchronous, `reset`=1 at a `clk` edge):
  - Outputs: `miso`=0, `tx_ready`=1, `rx_data`=0, `rx_valid`=0, `tx_underrun`=0, `busy`=0.
  - Internals: synchroniser chains preset to the idle level (`sclk` 0, `ss` 1, `mosi` 0), bit counter 0, shift registers 0, state IDLE.
  - Reset overrides all other activity, including mid-transfer; the master must then deassert `ss` before the next valid word.
- Synchronisation and edge detection:
  - `sclk`, `ss` and `mosi` each pass through SYNC_STAGES flops.
  - One extra flop on synchronised `sclk` and on synchronised `ss` provides edge detection.
  - `rise`/`fall` is a one-cycle strobe on a 0->1 / 1->0 transition of the synchronised signal.
- Transmit buffer:
  - `tx_load`=1 with `tx_ready`=1: `tx_buf`<=`tx_data`, and `tx_ready`=0 from the next cycle.
  - `tx_load` with `tx_ready`=0 is ignored; the buffer is not overwritten.
- State machine:
  - IDLE: `ss` synchronised high; `miso`=0; `sclk` edges ignored.
    - On `ss` fall: load `tx_shift` with `tx_buf` if full (set `tx_ready`=1), else with 0 and pulse `tx_underrun`.
    - Clear the bit counter and go to SHIFT.
    - If `tx_load` arrives in the same cycle with the buffer empty: the word sends 0, and `tx_data` is stored for the next word.
  - SHIFT: `miso` = `tx_shift[DATA_WIDTH-1]`.
    - `sclk` rise: `rx_shift` <= {`rx_shift[DATA_WIDTH-2:0]`, `mosi_s`}; counter +1.
    - Counter reaching DATA_WIDTH on that rise:
      - Next cycle: `rx_data` <= assembled word, `rx_valid`=1 for exactly one cycle.
      - Counter returns to 0 and `word_done` flag is set.
    - `sclk` fall with `word_done`=0: `tx_shift` <<= 1, zero fill.
    - `sclk` fall with `word_done`=1: reload `tx_shift` from `tx_buf` using the same full/empty/underrun rules as the `ss` fall, then clear `word_done`. This supports back-to-back words without deasserting `ss`.
    - `ss` rise: go to IDLE.
      - Counter and `word_done` clear.
      - A partial word is discarded; no `rx_valid`.
      - `tx_shift` clears; `tx_buf` is not restored if it was already consumed.
      - A completed word whose `rx_valid` is pending still issues it.
- Latency:
  - `rx_valid` rises SYNC_STAGES+2 `clk` cycles (±1 for phase) after the last pin-level `sclk` rise.
  - `miso` updates SYNC_STAGES+1 cycles (±1) after a pin-level `sclk` fall or `ss` fall.
- No receive backpressure: an unread `rx_data` is overwritten by the next word.
- `busy` = (state == SHIFT).

Test Plan:
- Reset, then `tx_load` 0xA5; master sends 0x3C in mode 0 at `clk`/8 -> `rx_data`=0x3C, a single `rx_valid` pulse; master captures 0xA5 on MISO; `tx_ready` returns to 1 at the `ss` fall.
- No `tx_load`, master sends 0xFF -> `tx_underrun` pulses once; MISO reads 0x00; `rx_data`=0xFF.
- `ss` held low for three words (0x01, 0x80, 0x55), with `tx_load` of 0x11, 0x22, 0x33 after each `tx_ready` rise -> three `rx_valid` pulses with the matching data; MISO returns 0x11, 0x22, 0x33.
- `ss` raised after 5 `sclk` rises -> no `rx_valid`; `rx_data` unchanged; `busy`=0; the next full word 0x96 is received correctly.
- `tx_load` 0x12 then `tx_load` 0x34 with no transfer between -> buffer keeps 0x12, and MISO sends 0x12.
- `reset` asserted mid-word (after 4 bits) -> all outputs reach their reset values on the next `clk`; after `ss` high/low, a word 0xC3 is received correctly.
